// File: rtl/decode_pkg.sv
// Shared opcode tables, pipe/state enums and the per-slot decode record for the
// dual-issue decode stage.
package decode_pkg;

    typedef enum logic {PIPE_EVEN, PIPE_ODD} pipe_e;

    typedef enum logic [1:0] {ST_NORMAL, ST_SQ1, ST_SQ_BOTH, ST_SQ0} state_e;

    // 11-bit opcodes (RR format)
    localparam logic [10:0] OP11_A      = 11'b00011000000;
    localparam logic [10:0] OP11_AH     = 11'b00011001000;
    localparam logic [10:0] OP11_AND    = 11'b00011000001;
    localparam logic [10:0] OP11_NOP    = 11'b01000000001;
    localparam logic [10:0] OP11_LNOP   = 11'b00000000001;
    localparam logic [10:0] OP11_LQX    = 11'b00111000100;
    localparam logic [10:0] OP11_STQX   = 11'b00101000100;
    localparam logic [10:0] OP11_ROTQBY = 11'b00111011100;

    // 9-bit opcodes (RI16 format)
    localparam logic [8:0] OP9_BR    = 9'b001100100;
    localparam logic [8:0] OP9_BRA   = 9'b001100000;
    localparam logic [8:0] OP9_IL    = 9'b010000001;
    localparam logic [8:0] OP9_BRZ   = 9'b001000000;
    localparam logic [8:0] OP9_BRNZ  = 9'b001000010;
    localparam logic [8:0] OP9_BRHZ  = 9'b001000100;
    localparam logic [8:0] OP9_BRHNZ = 9'b001000110;

    // 8-bit opcodes (RI10 format) and the 4-bit RRR shuffle
    localparam logic [7:0] OP8_AI    = 8'b00011100;
    localparam logic [7:0] OP8_LQD   = 8'b00110100;
    localparam logic [7:0] OP8_STQD  = 8'b00100100;
    localparam logic [3:0] OP4_SHUFB = 4'b1011;

    // src[0]=ra, src[1]=rb, src[2]=rc or store/condition rt (same bit field)
    typedef struct packed {
        pipe_e             pipe;
        logic              is_branch;
        logic              is_rel;
        logic              dst_v;
        logic [6:0]        dst;
        logic [2:0]        src_v;
        logic [2:0][6:0]   src;
    } dec_t;

    function automatic logic reg_hit(input logic v, input logic [6:0] a, input logic [6:0] b);
        return v && (a == b);
    endfunction

endpackage

// File: rtl/decode_instr_classify.sv
// Classifies one instruction slot: pipe, unconditional-branch flag, branch
// offset and register usage. Bit 0 of the instruction is its MSB.
module instr_classify
    import decode_pkg::*;
#(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 32
) (
    input  logic [INSTR_W-1:0] instr,
    output dec_t               dec,
    output logic [PC_W-1:0]    tgt_off
);

    localparam int M = INSTR_W - 1;

    logic [10:0] op11;
    logic [8:0]  op9;
    logic [7:0]  op8;
    logic [3:0]  op4;
    logic [6:0]  rt_f;
    logic [6:0]  ra_f;
    logic [6:0]  rb_f;
    logic [6:0]  rt_rrr_f;

    assign op11     = instr[M -: 11];
    assign op9      = instr[M -: 9];
    assign op8      = instr[M -: 8];
    assign op4      = instr[M -: 4];
    assign rt_f     = instr[M-25 -: 7];
    assign ra_f     = instr[M-18 -: 7];
    assign rb_f     = instr[M-11 -: 7];
    assign rt_rrr_f = instr[M-4 -: 7];
    assign tgt_off  = instr[M-24 +: PC_W];

    always_comb begin
        // Unknown opcodes decode as EVEN RR: conservative for hazard checks.
        dec           = '0;
        dec.pipe      = PIPE_EVEN;
        dec.dst_v     = 1'b1;
        dec.dst       = rt_f;
        dec.src_v     = 3'b011;
        dec.src       = {rt_f, rb_f, ra_f};
        if (op4 == OP4_SHUFB) begin
            dec.pipe  = PIPE_ODD;
            dec.dst   = rt_rrr_f;
            dec.src_v = 3'b111;
        end else if (op9 == OP9_BR || op9 == OP9_BRA) begin
            dec.pipe      = PIPE_ODD;
            dec.is_branch = 1'b1;
            dec.is_rel    = (op9 == OP9_BR);
            dec.dst_v     = 1'b0;
            dec.src_v     = 3'b000;
        end else if (op9 == OP9_BRZ || op9 == OP9_BRNZ || op9 == OP9_BRHZ || op9 == OP9_BRHNZ) begin
            dec.pipe  = PIPE_ODD;
            dec.dst_v = 1'b0;
            dec.src_v = 3'b100;
        end else if (op9 == OP9_IL) begin
            dec.src_v = 3'b000;
        end else if (op8 == OP8_AI) begin
            dec.src_v = 3'b001;
        end else if (op8 == OP8_LQD) begin
            dec.pipe  = PIPE_ODD;
            dec.src_v = 3'b001;
        end else if (op8 == OP8_STQD) begin
            dec.pipe  = PIPE_ODD;
            dec.dst_v = 1'b0;
            dec.src_v = 3'b101;
        end else begin
            case (op11)
                OP11_A, OP11_AH, OP11_AND: begin
                end
                OP11_NOP: begin
                    dec.dst_v = 1'b0;
                    dec.src_v = 3'b000;
                end
                OP11_LNOP: begin
                    dec.pipe  = PIPE_ODD;
                    dec.dst_v = 1'b0;
                    dec.src_v = 3'b000;
                end
                OP11_LQX, OP11_ROTQBY: begin
                    dec.pipe = PIPE_ODD;
                end
                OP11_STQX: begin
                    dec.pipe  = PIPE_ODD;
                    dec.dst_v = 1'b0;
                    dec.src_v = 3'b111;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/decode.sv
// Dual-issue decode: pairs the two fetched slots, detects pipe/register
// conflicts and unconditional branches, and drives fetch stall/redirect.
module decode
    import decode_pkg::*;
#(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [1:0][INSTR_W-1:0]   instr_d,
    input  logic [PC_W-1:0]           pc,
    output logic [PC_W-1:0]           pc_wb,
    output logic                      stall,
    output logic                      branch_taken
);

    dec_t            dec       [2];
    logic [PC_W-1:0] tgt_off   [2];
    logic [PC_W-1:0] slot_addr [2];
    logic [PC_W-1:0] tgt       [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
        instr_classify #(.PC_W(PC_W), .INSTR_W(INSTR_W)) u_classify (
            .instr   (instr_d[gi]),
            .dec     (dec[gi]),
            .tgt_off (tgt_off[gi])
        );
        assign slot_addr[gi] = pc - PC_W'(2 - gi);
        assign tgt[gi]       = dec[gi].is_rel ? slot_addr[gi] + tgt_off[gi] : tgt_off[gi];
    end

    state_e state_q, state_d;
    logic   odd_tgt_q, odd_tgt_d;
    logic   conflict;
    logic   redirect;
    logic [PC_W-1:0] target;

    assign conflict = (dec[0].pipe == dec[1].pipe) ||
                      (dec[0].dst_v &&
                       (reg_hit(dec[1].dst_v,    dec[1].dst,    dec[0].dst) ||
                        reg_hit(dec[1].src_v[0], dec[1].src[0], dec[0].dst) ||
                        reg_hit(dec[1].src_v[1], dec[1].src[1], dec[0].dst) ||
                        reg_hit(dec[1].src_v[2], dec[1].src[2], dec[0].dst)));

    always_comb begin
        stall        = 1'b0;
        branch_taken = 1'b0;
        pc_wb        = pc;
        state_d      = state_q;
        odd_tgt_d    = odd_tgt_q;
        redirect     = 1'b0;
        target       = pc;
        case (state_q)
            ST_NORMAL: begin
                if (dec[0].is_branch) begin
                    redirect = 1'b1;
                    target   = tgt[0];
                end else if (conflict) begin
                    stall   = 1'b1;
                    pc_wb   = slot_addr[1];
                    state_d = ST_SQ1;
                end else if (dec[1].is_branch) begin
                    redirect = 1'b1;
                    target   = tgt[1];
                end
            end
            ST_SQ1: begin
                state_d = ST_NORMAL;
                if (dec[0].is_branch) begin
                    redirect = 1'b1;
                    target   = tgt[0];
                end
            end
            // An odd target refetches the aligned pair, so its slot0 is stale.
            ST_SQ_BOTH: state_d = odd_tgt_q ? ST_SQ0 : ST_NORMAL;
            ST_SQ0: begin
                state_d = ST_NORMAL;
                if (dec[1].is_branch) begin
                    redirect = 1'b1;
                    target   = tgt[1];
                end
            end
            default: state_d = ST_NORMAL;
        endcase
        if (redirect) begin
            stall        = 1'b1;
            branch_taken = 1'b1;
            pc_wb        = target;
            state_d      = ST_SQ_BOTH;
            odd_tgt_d    = target[0];
        end
        if (!reset) begin
            stall        = 1'b0;
            branch_taken = 1'b0;
            pc_wb        = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_NORMAL;
            odd_tgt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            odd_tgt_q <= odd_tgt_d;
        end
    end

endmodule

// File: tb/tb_decode.sv
// Directed bench for the dual-issue decode stage: each step drives one fetched
// pair and checks stall, branch_taken and pc_wb against hand-computed values.
module tb_decode;

    localparam logic [10:0] A_OP      = 11'b00011000000;
    localparam logic [10:0] AH_OP     = 11'b00011001000;
    localparam logic [10:0] NOP_OP    = 11'b01000000001;
    localparam logic [10:0] LNOP_OP   = 11'b00000000001;
    localparam logic [10:0] UNK_OP    = 11'b11111111111;
    localparam logic [7:0]  LQD_OP    = 8'b00110100;
    localparam logic [7:0]  STQD_OP   = 8'b00100100;
    localparam logic [8:0]  BR_OP     = 9'b001100100;
    localparam logic [8:0]  BRA_OP    = 9'b001100000;
    localparam logic [8:0]  BRZ_OP    = 9'b001000000;

    logic              clk;
    logic              reset;
    logic [1:0][31:0]  instr_d;
    logic [7:0]        pc;
    logic [7:0]        pc_wb;
    logic              stall;
    logic              branch_taken;

    int passed = 0;
    int total  = 0;

    decode #(.PC_W(8), .INSTR_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .instr_d      (instr_d),
        .pc           (pc),
        .pc_wb        (pc_wb),
        .stall        (stall),
        .branch_taken (branch_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rr(input logic [10:0] op, input logic [6:0] rb, input logic [6:0] ra, input logic [6:0] rt);
        return {op, rb, ra, rt};
    endfunction

    function automatic logic [31:0] ri10(input logic [7:0] op, input logic [6:0] ra, input logic [6:0] rt);
        return {op, 10'd0, ra, rt};
    endfunction

    function automatic logic [31:0] ri16(input logic [8:0] op, input logic [15:0] i16, input logic [6:0] rt);
        return {op, i16, rt};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step(input string tag, input logic rst_n, input logic [31:0] i0, input logic [31:0] i1,
                        input logic [7:0] p, input logic es, input logic eb, input logic [7:0] ew);
        @(negedge clk);
        reset      = rst_n;
        instr_d[0] = i0;
        instr_d[1] = i1;
        pc         = p;
        #1;
        $display("step %s: pc=%0d stall=%0d branch_taken=%0d pc_wb=%0d", tag, p, stall, branch_taken, pc_wb);
        chk({tag, ".stall"}, 32'(stall), 32'(es));
        chk({tag, ".branch_taken"}, 32'(branch_taken), 32'(eb));
        chk({tag, ".pc_wb"}, 32'(pc_wb), 32'(ew));
    endtask

    logic [31:0] a3, ah5, lqd4, benign1;

    initial begin
        a3      = rr(A_OP, 7'd2, 7'd1, 7'd3);
        ah5     = rr(AH_OP, 7'd7, 7'd6, 7'd5);
        lqd4    = ri10(LQD_OP, 7'd5, 7'd4);
        benign1 = lqd4;
        reset   = 1'b0;
        instr_d = '0;
        pc      = '0;

        step("reset_hold",    1'b0, ri16(BRA_OP, 16'h0040, 7'd0), a3, 8'd30, 1'b0, 1'b0, 8'd0);
        step("reset_hold2",   1'b0, ri16(BRA_OP, 16'h0040, 7'd0), a3, 8'd30, 1'b0, 1'b0, 8'd0);
        step("dual_issue",    1'b1, a3, lqd4, 8'd10, 1'b0, 1'b0, 8'd10);
        step("even_even",     1'b1, a3, ah5, 8'd10, 1'b1, 1'b0, 8'd9);
        step("sq1_ignore",    1'b1, a3, ah5, 8'd10, 1'b0, 1'b0, 8'd10);
        step("back_normal",   1'b1, a3, ah5, 8'd10, 1'b1, 1'b0, 8'd9);
        step("sq1_clear",     1'b1, a3, benign1, 8'd20, 1'b0, 1'b0, 8'd20);
        step("raw_ra",        1'b1, a3, ri10(LQD_OP, 7'd3, 7'd4), 8'd20, 1'b1, 1'b0, 8'd19);
        step("sq1_after_raw", 1'b1, a3, benign1, 8'd21, 1'b0, 1'b0, 8'd21);
        step("bra_slot0",     1'b1, ri16(BRA_OP, 16'h0040, 7'd0), rr(A_OP, 7'd2, 7'd1, 7'd8), 8'd30, 1'b1, 1'b1, 8'd64);
        step("sq_both",       1'b1, ri16(BRA_OP, 16'h0040, 7'd0), ri16(BRA_OP, 16'h0041, 7'd0), 8'd32, 1'b0, 1'b0, 8'd32);
        step("nop_nop",       1'b1, rr(NOP_OP, 7'd0, 7'd0, 7'd0), rr(NOP_OP, 7'd0, 7'd0, 7'd0), 8'd64, 1'b1, 1'b0, 8'd63);
        step("sq1_lnop",      1'b1, rr(LNOP_OP, 7'd0, 7'd0, 7'd0), rr(NOP_OP, 7'd0, 7'd0, 7'd0), 8'd64, 1'b0, 1'b0, 8'd64);
        step("lnop_nop",      1'b1, rr(LNOP_OP, 7'd0, 7'd0, 7'd0), rr(NOP_OP, 7'd0, 7'd0, 7'd0), 8'd66, 1'b0, 1'b0, 8'd66);
        step("store_src",     1'b1, a3, ri10(STQD_OP, 7'd9, 7'd3), 8'd70, 1'b1, 1'b0, 8'd69);
        step("sq1_store",     1'b1, a3, benign1, 8'd70, 1'b0, 1'b0, 8'd70);
        step("brz_odd_odd",   1'b1, ri16(BRZ_OP, 16'h0040, 7'd2), lqd4, 8'd80, 1'b1, 1'b0, 8'd79);
        step("sq1_brz",       1'b1, ri16(BRZ_OP, 16'h0040, 7'd2), a3, 8'd80, 1'b0, 1'b0, 8'd80);
        step("br_slot1_wrap", 1'b1, a3, ri16(BR_OP, 16'h0009, 7'd0), 8'd252, 1'b1, 1'b1, 8'd4);
        step("sq_both_even",  1'b1, a3, benign1, 8'd6, 1'b0, 1'b0, 8'd6);
        step("waw",           1'b1, a3, ri10(LQD_OP, 7'd5, 7'd3), 8'd100, 1'b1, 1'b0, 8'd99);
        step("sq1_waw",       1'b1, a3, benign1, 8'd100, 1'b0, 1'b0, 8'd100);
        step("br_odd_tgt",    1'b1, ri16(BR_OP, 16'h0005, 7'd0), a3, 8'd2, 1'b1, 1'b1, 8'd5);
        step("sq_both_odd",   1'b1, a3, ah5, 8'd6, 1'b0, 1'b0, 8'd6);
        step("sq0_ign_slot0", 1'b1, ri16(BRA_OP, 16'h0040, 7'd0), ah5, 8'd6, 1'b0, 1'b0, 8'd6);
        step("normal_again",  1'b1, a3, ah5, 8'd8, 1'b1, 1'b0, 8'd7);
        step("sq1_clear2",    1'b1, a3, benign1, 8'd8, 1'b0, 1'b0, 8'd8);
        step("br_odd_tgt2",   1'b1, ri16(BR_OP, 16'h0005, 7'd0), a3, 8'd2, 1'b1, 1'b1, 8'd5);
        step("sq_both_odd2",  1'b1, a3, benign1, 8'd6, 1'b0, 1'b0, 8'd6);
        step("sq0_br_slot1",  1'b1, a3, ri16(BR_OP, 16'h0003, 7'd0), 8'd6, 1'b1, 1'b1, 8'd8);
        step("sq_both_even2", 1'b1, a3, benign1, 8'd10, 1'b0, 1'b0, 8'd10);
        step("unknown_lnop",  1'b1, rr(UNK_OP, 7'd2, 7'd1, 7'd3), rr(LNOP_OP, 7'd0, 7'd0, 7'd0), 8'd40, 1'b0, 1'b0, 8'd40);
        step("unknown_even",  1'b1, rr(UNK_OP, 7'd2, 7'd1, 7'd3), ah5, 8'd40, 1'b1, 1'b0, 8'd39);
        step("sq1_unknown",   1'b1, a3, benign1, 8'd41, 1'b0, 1'b0, 8'd41);
        step("br_before_rst", 1'b1, ri16(BR_OP, 16'h0005, 7'd0), a3, 8'd2, 1'b1, 1'b1, 8'd5);
        step("rst_in_sqboth", 1'b0, ri16(BRA_OP, 16'h0040, 7'd0), a3, 8'd30, 1'b0, 1'b0, 8'd0);
        step("after_rst",     1'b1, a3, ah5, 8'd10, 1'b1, 1'b0, 8'd9);
        step("after_rst_sq1", 1'b1, a3, benign1, 8'd10, 1'b0, 1'b0, 8'd10);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
